// File: rtl/layer_seq.sv
// layer_seq: sequenced fixed-point neural layer. It evaluates sm neurons of
// sx inputs each through one shared multiply-accumulate unit.
// Fixed-point format is [i:-f] = 32 bits (1 sign, 7 integer, 24 fraction).
// Optional feature: define LAYER_SAT_EN to clamp z[k] on overflow instead
// of wrapping.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request an evaluation (accepted only while busy = 0)
//   nx     packed inputs   x[j]    = nx[j*32 +: 32]
//   nw     packed weights  w[k][j] = nw[(k*sx+j)*32 +: 32]
//   nb     packed biases   b[k]    = nb[k*32 +: 32]
//   busy   evaluation in progress
//   done   one-cycle pulse; nz/ny updated on the same edge
//   nz     packed pre-activation sums z[k]
//   ny     packed activations y[k] = relu(z[k])
module layer_seq #(
    parameter int unsigned sx = 2,
    parameter int unsigned sm = 2,
    localparam int unsigned N = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*sx-1:0]    nx,
    input  logic [N*sx*sm-1:0] nw,
    input  logic [N*sm-1:0]    nb,
    output logic               busy,
    output logic               done,
    output logic [N*sm-1:0]    nz,
    output logic [N*sm-1:0]    ny
);
    localparam int unsigned IB = 7;
    localparam int unsigned FB = 24;
    localparam int unsigned AW = 2 * N;
    localparam int unsigned KW = (sm > 1) ? $clog2(sm) : 1;
    localparam int unsigned JW = (sx > 1) ? $clog2(sx) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BIAS = 2'd1;
    localparam logic [1:0] S_MAC  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [JW-1:0]      j_q, j_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [N*sx-1:0]    x_q, x_d;
    logic [N*sx*sm-1:0] w_q, w_d;
    logic [N*sm-1:0]    b_q, b_d;
    logic [N-1:0]       zs_q [sm];
    logic [N-1:0]       zs_d [sm];
    logic [N-1:0]       ys_q [sm];
    logic [N-1:0]       ys_d [sm];
    logic [N-1:0]       nz_q [sm];
    logic [N-1:0]       nz_d [sm];
    logic [N-1:0]       ny_q [sm];
    logic [N-1:0]       ny_d [sm];
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Word views of the captured operand buses.
    logic signed [N-1:0] x_a [sx];
    logic signed [N-1:0] w_a [sm][sx];
    logic signed [N-1:0] b_a [sm];

    for (genvar gj = 0; gj < sx; gj++) begin : g_x
        assign x_a[gj] = x_q[gj*N +: N];
    end
    for (genvar gk = 0; gk < sm; gk++) begin : g_kw
        assign b_a[gk] = b_q[gk*N +: N];
        assign nz[gk*N +: N] = nz_q[gk];
        assign ny[gk*N +: N] = ny_q[gk];
        for (genvar gj = 0; gj < sx; gj++) begin : g_w
            assign w_a[gk][gj] = w_q[(gk*sx+gj)*N +: N];
        end
    end

    // The single multiplier: full-width signed product of x[j] and w[k][j].
    logic signed [AW-1:0] prod_c;
    assign prod_c = $signed(AW'(x_a[j_q])) * $signed(AW'(w_a[k_q][j_q]));

    // Bias aligned to the accumulator format [2i+1:-2f].
    logic [AW-1:0] bias_c;
    assign bias_c = {{(IB+1){b_a[k_q][N-1]}}, b_a[k_q], {FB{1'b0}}};

    // Accumulator reduced back to [i:-f].
    logic [N-1:0] z_c, y_c;
`ifdef LAYER_SAT_EN
    logic [AW-FB-N:0] acc_hi;
    logic             acc_ovf;
    assign acc_hi  = acc_q[AW-1:FB+N-1];
    // In range only when every bit above the result sign matches it.
    assign acc_ovf = ~((&acc_hi) | ~(|acc_hi));
    assign z_c = !acc_ovf    ? acc_q[FB +: N] :
                 acc_q[AW-1] ? {1'b1, {(N-1){1'b0}}} :
                               {1'b0, {(N-1){1'b1}}};
`else
    assign z_c = acc_q[FB +: N];
`endif
    assign y_c = z_c[N-1] ? '0 : z_c;

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        acc_d   = acc_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        zs_d    = zs_q;
        ys_d    = ys_q;
        nz_d    = nz_q;
        ny_d    = ny_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = nx;
                    w_d     = nw;
                    b_d     = nb;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                acc_d   = bias_c;
                j_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + prod_c;
                if (j_q == JW'(sx - 1)) begin
                    state_d = S_WB;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            default: begin
                zs_d[k_q] = z_c;
                ys_d[k_q] = y_c;
                if (k_q != KW'(sm - 1)) begin
                    k_d     = k_q + KW'(1);
                    state_d = S_BIAS;
                end else begin
                    // Publish all neurons at once, including the one just written.
                    nz_d    = zs_d;
                    ny_d    = ys_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    k_d     = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
            zs_q    <= '{default: '0};
            ys_q    <= '{default: '0};
            nz_q    <= '{default: '0};
            ny_q    <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            w_q     <= w_d;
            b_q     <= b_d;
            zs_q    <= zs_d;
            ys_q    <= ys_d;
            nz_q    <= nz_d;
            ny_q    <= ny_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_layer_seq.sv
// Testbench for layer_seq with default parameters (sx = sm = 2).
module tb_layer_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [63:0]  nx = '0;
    logic [127:0] nw = '0;
    logic [63:0]  nb = '0;
    logic         busy, done;
    logic [63:0]  nz, ny;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] xv [2];
    logic [31:0] wv [2][2];
    logic [31:0] bv [2];
    logic [31:0] ez [2];
    logic [31:0] ey [2];
    logic [31:0] dz [2];
    logic [31:0] dy [2];

    assign dz[0] = nz[31:0];
    assign dz[1] = nz[63:32];
    assign dy[0] = ny[31:0];
    assign dy[1] = ny[63:32];

    layer_seq #(.sx(2), .sm(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .nx(nx), .nw(nw), .nb(nb),
        .busy(busy), .done(done), .nz(nz), .ny(ny)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: exact 64-bit sum of bias and products, then rescale by 2^-24.
    task automatic model();
        longint acc;
        longint sc;
        for (int k = 0; k < 2; k++) begin
            acc = longint'($signed(bv[1'(k)])) <<< 24;
            for (int j = 0; j < 2; j++)
                acc += longint'($signed(xv[1'(j)])) * longint'($signed(wv[1'(k)][1'(j)]));
            sc = acc >>> 24;
`ifdef LAYER_SAT_EN
            if (sc > 64'sd2147483647)       ez[1'(k)] = 32'h7FFF_FFFF;
            else if (sc < -64'sd2147483648) ez[1'(k)] = 32'h8000_0000;
            else                            ez[1'(k)] = 32'(sc);
`else
            ez[1'(k)] = 32'(sc);
`endif
            ey[1'(k)] = ($signed(ez[1'(k)]) < 0) ? 32'h0 : ez[1'(k)];
        end
    endtask

    task automatic drive_ops();
        nx = {xv[1], xv[0]};
        nw = {wv[1][1], wv[1][0], wv[0][1], wv[0][0]};
        nb = {bv[1], bv[0]};
    endtask

    task automatic set_nominal();
        xv[0] = 32'h0100_0000; xv[1] = 32'h0200_0000;
        wv[0][0] = 32'h0080_0000; wv[0][1] = 32'h0040_0000; bv[0] = 32'h0040_0000;
        wv[1][0] = 32'hFF00_0000; wv[1][1] = 32'hFF00_0000; bv[1] = 32'h0080_0000;
    endtask

    task automatic set_random();
        for (int k = 0; k < 2; k++) begin
            xv[1'(k)] = $urandom;
            bv[1'(k)] = $urandom;
            for (int j = 0; j < 2; j++) wv[1'(k)][1'(j)] = $urandom;
        end
    endtask

    // Called just after an edge; the following edge samples start (E0).
    task automatic start_op();
        drive_ops();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen (bounded).
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bad = (busy !== 1'b0) || (done !== 1'b0) || (nz !== 64'h0) || (ny !== 64'h0);
            nvec++;
            if (bad) begin
                nerr++;
                $display("FAIL reset_idle c%0d: busy=%b done=%b nz=%h ny=%h required 0", c, busy, done, nz, ny);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nominal();
        int cyc; bit bok;
        set_nominal();
        start_op();
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL nom_busy_rise: got %b required 1", busy); end
        wait_done(cyc, bok);
        nvec++;
        if (cyc !== 8) begin nerr++; $display("FAIL nom_latency: got %0d required 8", cyc); end
        nvec++;
        if (bok !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL nom_busy: held=%b at_done=%b required 1/0", bok, busy); end
        nvec++;
        if (dz[0] !== 32'h0140_0000 || dy[0] !== 32'h0140_0000) begin
            nerr++; $display("FAIL nom_n0: z=%h y=%h required 01400000/01400000", dz[0], dy[0]);
        end
        nvec++;
        if (dz[1] !== 32'hFD80_0000 || dy[1] !== 32'h0) begin
            nerr++; $display("FAIL nom_n1: z=%h y=%h required fd800000/00000000", dz[1], dy[1]);
        end
        @(posedge clk); #1;
        nvec++;
        if (done !== 1'b0) begin nerr++; $display("FAIL nom_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_overflow();
        int cyc; bit bok;
        logic [31:0] want;
`ifdef LAYER_SAT_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'h2000_0000;
`endif
        xv[0] = 32'h6400_0000; xv[1] = 32'h6400_0000;
        wv[0][0] = 32'h6400_0000; wv[0][1] = 32'h6400_0000; bv[0] = 32'h0;
        wv[1][0] = 32'h0; wv[1][1] = 32'h0; bv[1] = 32'h0;
        start_op();
        wait_done(cyc, bok);
        nvec++;
        if (cyc !== 8 || dz[0] !== want || dy[0] !== want) begin
            nerr++; $display("FAIL overflow: cyc=%0d z=%h y=%h required 8/%h/%h", cyc, dz[0], dy[0], want, want);
        end
    endtask

    task automatic test_random();
        int cyc; bit bok;
        for (int t = 0; t < 20; t++) begin
            set_random();
            model();
            start_op();
            wait_done(cyc, bok);
            nvec++;
            if (cyc !== 8 || bok !== 1'b1) begin
                nerr++; $display("FAIL rand_timing t%0d: cyc=%0d busy_held=%b required 8/1", t, cyc, bok);
            end
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (dz[1'(k)] !== ez[1'(k)] || dy[1'(k)] !== ey[1'(k)]) begin
                    nerr++;
                    $display("FAIL rand_n%0d t%0d: z=%h y=%h required %h/%h", k, t, dz[1'(k)], dy[1'(k)], ez[1'(k)], ey[1'(k)]);
                end
            end
        end
    endtask

    task automatic test_capture();
        int cyc; bit bok; int ndone;
        set_nominal();
        start_op();
        repeat (2) begin @(posedge clk); #1; end
        nx = {$urandom, $urandom};
        nw = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bok);
        nvec++;
        if (cyc + 3 !== 8) begin nerr++; $display("FAIL cap_latency: got %0d required 8", cyc + 3); end
        nvec++;
        if (dz[0] !== 32'h0140_0000 || dz[1] !== 32'hFD80_0000 || dy[0] !== 32'h0140_0000 || dy[1] !== 32'h0) begin
            nerr++; $display("FAIL cap_result: nz=%h ny=%h required fd80000001400000/0000000001400000", nz, ny);
        end
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        nvec++;
        if (ndone !== 0) begin nerr++; $display("FAIL cap_no_rerun: active cycles=%0d required 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit bok;
        set_random();
        start_op();
        wait_done(cyc, bok);
        // In the done cycle: launch a new evaluation immediately.
        set_random();
        model();
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            nerr++; $display("FAIL b2b_gap: done=%b busy=%b required 1/0", done, busy);
        end
        start_op();
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_restart: busy=%b required 1", busy); end
        wait_done(cyc, bok);
        nvec++;
        if (cyc !== 8 || bok !== 1'b1) begin
            nerr++; $display("FAIL b2b_latency: cyc=%0d busy_held=%b required 8/1", cyc, bok);
        end
        nvec++;
        if (dz[0] !== ez[0] || dz[1] !== ez[1] || dy[0] !== ey[0] || dy[1] !== ey[1]) begin
            nerr++; $display("FAIL b2b_result: nz=%h ny=%h required %h%h/%h%h", nz, ny, ez[1], ez[0], ey[1], ey[0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit bok; int act;
        set_random();
        start_op();
        // Five edges after E0 the FSM enters neuron 1 MAC; reset there.
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || nz !== 64'h0 || ny !== 64'h0) begin
            nerr++; $display("FAIL rstmid_clear: busy=%b done=%b nz=%h ny=%h required 0", busy, done, nz, ny);
        end
        act = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done || busy) act++;
        end
        nvec++;
        if (act !== 0) begin nerr++; $display("FAIL rstmid_no_done: active cycles=%0d required 0", act); end
        set_nominal();
        start_op();
        wait_done(cyc, bok);
        nvec++;
        if (cyc !== 8 || dz[0] !== 32'h0140_0000 || dz[1] !== 32'hFD80_0000 || dy[1] !== 32'h0) begin
            nerr++; $display("FAIL rstmid_rerun: cyc=%0d nz=%h required 8/fd80000001400000", cyc, nz);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow();
        test_random();
        test_capture();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
